// File: rtl/div_sequential_restoring.sv
// rtl/div_sequential_restoring.sv - W-bit unsigned sequential restoring divider, one quotient bit per clock.
// Optional DIV_SEQUENTIAL_DIVZ_EN: a zero divisor finishes one cycle after acceptance with o_dz set.
module div_sequential_restoring #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_valid,
  output logic [W-1:0] o_quo,
  output logic [W-1:0] o_rem,
  output logic         o_dz
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] pr_q, pr_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           valid_q, valid_d;

`ifdef DIV_SEQUENTIAL_DIVZ_EN
  logic           zdiv_q, zdiv_d;
  logic           dz_q, dz_d;
  assign o_dz = dz_q;
`else
  assign o_dz = 1'b0;
`endif

  logic [W:0]     pr_shift;
  logic [W-1:0]   trial;
  logic           fits;
  logic [2*W-1:0] pr_step;
  logic           accept;
  logic           last;

  // pr_q holds {partial remainder, remaining dividend bits / quotient bits so far}.
  // The shifted remainder needs W+1 bits; when it is >= divisor the difference fits in W bits.
  always_comb begin
    pr_shift = pr_q[2*W-1:W-1];
    fits     = (pr_shift >= {1'b0, dvs_q});
    trial    = pr_shift[W-1:0] - dvs_q;
    if (fits) begin
      pr_step = {trial, pr_q[W-2:0], 1'b1};
    end else begin
      pr_step = {pr_shift[W-1:0], pr_q[W-2:0], 1'b0};
    end
  end

  assign accept = i_start && (state_q != S_CALC);
  assign last   = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
`ifdef DIV_SEQUENTIAL_DIVZ_EN
    zdiv_d  = zdiv_q;
    dz_d    = dz_q;
`endif

    case (state_q)
      S_IDLE: ;
      S_CALC: begin
`ifdef DIV_SEQUENTIAL_DIVZ_EN
        if (zdiv_q) begin
          state_d = S_DONE;
          quo_d   = '1;
          rem_d   = pr_q[W-1:0];
          dz_d    = 1'b1;
          valid_d = 1'b1;
        end else begin
`endif
          pr_d  = pr_step;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = S_DONE;
            quo_d   = pr_step[W-1:0];
            rem_d   = pr_step[2*W-1:W];
            valid_d = 1'b1;
`ifdef DIV_SEQUENTIAL_DIVZ_EN
            dz_d    = 1'b0;
`endif
          end
`ifdef DIV_SEQUENTIAL_DIVZ_EN
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A start in DONE overrides the return to IDLE and drops o_valid.
    if (accept) begin
      state_d = S_CALC;
      cnt_d   = '0;
      pr_d    = {{W{1'b0}}, i_dividend};
      dvs_d   = i_divisor;
`ifdef DIV_SEQUENTIAL_DIVZ_EN
      zdiv_d  = (i_divisor == '0);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
`ifdef DIV_SEQUENTIAL_DIVZ_EN
      zdiv_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
`ifdef DIV_SEQUENTIAL_DIVZ_EN
      zdiv_q  <= zdiv_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign o_busy  = (state_q == S_CALC);
  assign o_valid = valid_q;
  assign o_quo   = quo_q;
  assign o_rem   = rem_q;

endmodule

// File: tb/tb_div_sequential_restoring.sv
// tb/tb_div_sequential_restoring.sv - scoreboard bench for div_sequential_restoring at W=8.
module tb_div_sequential_restoring;

  localparam int W = 8;
`ifdef DIV_SEQUENTIAL_DIVZ_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         i_clk;
  logic         i_rst;
  logic         i_start;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         o_busy;
  logic         o_valid;
  logic [W-1:0] o_quo;
  logic [W-1:0] o_rem;
  logic         o_dz;

  div_sequential_restoring #(.W(W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_quo      (o_quo),
    .o_rem      (o_rem),
    .o_dz       (o_dz)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    if (b == '0) begin
      e.quo = '1;
      e.rem = a;
      e.dz  = DZ_EN;
    end else begin
      e.quo = a / b;
      e.rem = a % b;
      e.dz  = 1'b0;
    end
    sb.push_back(e);
    i_start    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    tick();
    i_start    = 1'b0;
    check("busy_after_accept", 32'(o_busy), 32'd1);
  endtask

  task automatic wait_result(input int lat, input string tag);
    int   n;
    int   bad;
    res_t e;
    n   = 0;
    bad = 0;
    do begin
      tick();
      n++;
      if (!o_valid && !o_busy) bad++;
    end while (!o_valid && n < 40);
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_gap"}, 32'(bad), 32'd0);
    check({tag, "_busy_done"}, 32'(o_busy), 32'd0);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    check({tag, "_quo"}, 32'(o_quo), 32'(e.quo));
    check({tag, "_rem"}, 32'(o_rem), 32'(e.rem));
    check({tag, "_dz"}, 32'(o_dz), 32'(e.dz));
  endtask

  initial begin
    int vcnt;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    tick();
    tick();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_quo", 32'(o_quo), 32'd0);
    check("rst_rem", 32'(o_rem), 32'd0);
    check("rst_dz", 32'(o_dz), 32'd0);
    i_rst = 1'b0;
    tick();

    // 100/7
    start(8'd100, 8'd7);
    wait_result(8, "d100_7");
    tick();
    check("d100_7_pulse_end", 32'(o_valid), 32'd0);
    check("d100_7_quo_hold", 32'(o_quo), 32'd14);
    check("d100_7_rem_hold", 32'(o_rem), 32'd2);

    // 255/1 then 5/10 back-to-back from DONE
    start(8'd255, 8'd1);
    wait_result(8, "d255_1");
    start(8'd5, 8'd10);
    check("b2b_valid_cleared", 32'(o_valid), 32'd0);
    wait_result(8, "d5_10");

    // divide by zero
    start(8'd200, 8'd0);
    wait_result(DZ_EN ? 1 : 8, "d200_0");

    // 77/3 with an ignored start at k+3
    start(8'd77, 8'd3);
    tick();
    tick();
    i_start    = 1'b1;
    i_dividend = 8'd9;
    i_divisor  = 8'd9;
    tick();
    i_start    = 1'b0;
    check("ign_busy", 32'(o_busy), 32'd1);
    wait_result(5, "d77_3");

    // a few random nonzero divisors
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      start(ra, rb);
      wait_result(8, "rand");
    end

    // 150/4 aborted by reset around k+4
    start(8'd150, 8'd4);
    tick();
    tick();
    tick();
    check("abort_busy_pre", 32'(o_busy), 32'd1);
    #3;
    i_rst = 1'b1;
    #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_quo", 32'(o_quo), 32'd0);
    check("abort_rem", 32'(o_rem), 32'd0);
    check("abort_dz", 32'(o_dz), 32'd0);
    sb.delete(sb.size() - 1);
    tick();
    tick();
    i_rst = 1'b0;
    vcnt  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_valid) vcnt++;
    end
    check("abort_no_valid", 32'(vcnt), 32'd0);
    check("abort_idle", 32'(o_busy), 32'd0);

    start(8'd9, 8'd9);
    wait_result(8, "d9_9");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
